// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters the pins, deframes 11-bit frames and
// folds E0/F0 prefixes into one key event. Define PS2_TIMEOUT_EN to enable the mid-frame timeout.
module ps2_scancode_rx #(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       strobe,
  output logic       pressed,
  output logic       extended,
  output logic       frame_err
);

  localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  logic [1:0]    state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic          par_q, par_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [7:0]    code_q, code_d;
  logic          pressed_q, pressed_d;
  logic          extended_q, extended_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;

  // Filtered clock flips only after FILTER consecutive samples disagreeing with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER - 1)) begin
        filt_d = ~filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  logic          to_hit;

  always_comb begin
    to_d = '0;
    if (!fall && state_q != StIdle) begin
      to_d = to_q + 1'b1;
    end
  end

  assign to_hit = (state_q != StIdle) && (to_q == TW'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (reset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  logic to_hit;
  logic unused_timeout_cfg;
  assign to_hit             = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bcnt_d     = bcnt_q;
    par_d      = par_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    code_d     = code_q;
    pressed_d  = pressed_q;
    extended_d = extended_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    if (fall) begin
      case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d = StData;
            bcnt_d  = '0;
          end
        end
        StData: begin
          sh_d   = {dat_s2_q, sh_q[7:1]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
        default: begin
          state_d = StIdle;
          if (dat_s2_q && ((^sh_q) ^ par_q)) begin
            if (sh_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (sh_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              code_d     = sh_q;
              pressed_d  = ~brk_q;
              extended_d = ext_q;
              strobe_d   = 1'b1;
              ext_d      = 1'b0;
              brk_d      = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      endcase
    end else if (to_hit) begin
      // Abandon the partial byte but keep any prefix already seen.
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= StIdle;
      sh_q       <= '0;
      bcnt_q     <= '0;
      par_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      code_q     <= '0;
      pressed_q  <= 1'b0;
      extended_q <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      sh_q       <= sh_d;
      bcnt_q     <= bcnt_d;
      par_q      <= par_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      code_q     <= code_d;
      pressed_q  <= pressed_d;
      extended_q <= extended_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  assign code      = code_q;
  assign strobe    = strobe_q;
  assign pressed   = pressed_q;
  assign extended  = extended_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomized bench for ps2_scancode_rx against a frame-level event model.
// Build with PS2_TIMEOUT_EN defined to also exercise the mid-frame timeout.
module tb_ps2_scancode_rx;

  localparam int unsigned FILTER = 8;
`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 100;
`else
  localparam int unsigned TIMEOUT = 50000;
`endif
  localparam int unsigned LAT = FILTER + 2;  // pin edge to strobe, in clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       strobe, pressed, extended, frame_err;

  ps2_scancode_rx #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code     (code),
    .strobe   (strobe),
    .pressed  (pressed),
    .extended (extended),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  code;
    logic        pressed;
    logic        extended;
  } ev_t;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          both_cnt = 0;
  ev_t         obs_ev[$];
  ev_t         exp_ev[$];
  int unsigned obs_err[$];
  int unsigned exp_err[$];
  logic        m_ext = 1'b0;
  logic        m_brk = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (strobe) begin
        ev_t e;
        e.cyc = cyc; e.code = code; e.pressed = pressed; e.extended = extended;
        obs_ev.push_back(e);
      end
      if (frame_err) obs_err.push_back(cyc);
      if (strobe && frame_err) both_cnt++;
    end
  end

  task automatic clear_q;
    obs_ev.delete(); exp_ev.delete(); obs_err.delete(); exp_err.delete();
  endtask

  // Drive one frame and apply the protocol rules to the expected-event model.
  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input int half, input int glitch_bit);
    logic [10:0] bits;
    int unsigned stop_cyc;
    ev_t         e;
    stop_cyc = 0;
    bits = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clock); ps2_data = bits[i];
      if (i == glitch_bit) begin
        repeat (FILTER + 6) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (FILTER - 1) @(negedge clock);
        ps2_clk = 1'b1;
      end
      repeat (half) @(negedge clock);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (half) @(negedge clock);
      ps2_clk = 1'b1;
    end
    @(negedge clock); ps2_data = 1'b1;
    repeat (half) @(negedge clock);
    if (par_bad || stop_bad) begin
      exp_err.push_back(stop_cyc + LAT);
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      e.cyc = stop_cyc + LAT; e.code = b; e.pressed = ~m_brk; e.extended = m_ext;
      exp_ev.push_back(e);
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits, input int half);
    for (int i = 0; i <= nbits; i++) begin
      @(negedge clock); ps2_data = (i == 0) ? 1'b0 : b[i-1];
      repeat (half) @(negedge clock); ps2_clk = 1'b0;
      repeat (half) @(negedge clock); ps2_clk = 1'b1;
    end
    @(negedge clock); ps2_data = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if ({code, strobe, pressed, extended, frame_err} !== 12'h0) begin
      fails++;
      $display("FAIL reset_init: got %h expected 000", {code, strobe, pressed, extended, frame_err});
    end
    reset = 1'b0;
    repeat (LAT + 4) @(negedge clock);
    clear_q(); m_ext = 1'b0; m_brk = 1'b0;
    send_frame(8'h1C, 0, 0, FILTER + 6, -1);
    send_partial(8'hA5, 4, FILTER + 6);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if ({code, strobe, pressed, extended, frame_err} !== 12'h0) begin
      fails++;
      $display("FAIL reset_mid: got %h expected 000", {code, strobe, pressed, extended, frame_err});
    end
    tests++;
    if (obs_ev.size() != 1 || obs_err.size() != 0) begin
      fails++;
      $display("FAIL reset_pre_events: got %0d/%0d expected 1/0", obs_ev.size(), obs_err.size());
    end
    reset = 1'b0;
    repeat (LAT + 4) @(negedge clock);
    clear_q(); m_ext = 1'b0; m_brk = 1'b0;
    send_frame(8'h1C, 0, 0, FILTER + 6, -1);
    tests++;
    if (obs_ev.size() != 1 || obs_err.size() != 0) begin
      fails++;
      $display("FAIL reset_after_count: got %0d/%0d expected 1/0", obs_ev.size(), obs_err.size());
    end else begin
      tests++;
      if (obs_ev[0] !== exp_ev[0] || {obs_ev[0].code, obs_ev[0].pressed, obs_ev[0].extended}
          !== {8'h1C, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reset_after_ev: got cyc=%0d code=%h p=%b x=%b expected cyc=%0d code=1c p=1 x=0",
                 obs_ev[0].cyc, obs_ev[0].code, obs_ev[0].pressed, obs_ev[0].extended,
                 exp_ev[0].cyc);
      end
    end
  endtask

  task automatic test_make_break;
    clear_q();
    send_frame(8'h1C, 0, 0, FILTER + 5, -1);
    send_frame(8'hF0, 0, 0, FILTER + 5, -1);
    send_frame(8'h1C, 0, 0, FILTER + 5, -1);
    repeat (20) @(negedge clock);
    tests++;
    if (obs_ev.size() != 2) begin
      fails++;
      $display("FAIL make_break_count: got %0d expected 2", obs_ev.size());
    end
    for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
      tests++;
      if (obs_ev[i] !== exp_ev[i]) begin
        fails++;
        $display("FAIL make_break_ev%0d: got cyc=%0d code=%h p=%b x=%b expected cyc=%0d code=%h p=%b x=%b",
                 i, obs_ev[i].cyc, obs_ev[i].code, obs_ev[i].pressed, obs_ev[i].extended,
                 exp_ev[i].cyc, exp_ev[i].code, exp_ev[i].pressed, exp_ev[i].extended);
      end
    end
    tests++;
    if ({code, pressed, extended} !== {8'h1C, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL make_break_hold: got %h/%b/%b expected 1c/0/0", code, pressed, extended);
    end
  endtask

  task automatic test_extended;
    clear_q();
    send_frame(8'hE0, 0, 0, FILTER + 7, -1);
    send_frame(8'h75, 0, 0, FILTER + 7, -1);
    send_frame(8'hE0, 0, 0, FILTER + 7, -1);
    send_frame(8'hF0, 0, 0, FILTER + 7, -1);
    send_frame(8'h75, 0, 0, FILTER + 7, -1);
    send_frame(8'h75, 0, 0, FILTER + 7, -1);
    tests++;
    if (obs_ev.size() != 3 || exp_ev.size() != 3) begin
      fails++;
      $display("FAIL extended_count: got %0d expected 3", obs_ev.size());
    end
    for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
      tests++;
      if (obs_ev[i] !== exp_ev[i]) begin
        fails++;
        $display("FAIL extended_ev%0d: got cyc=%0d code=%h p=%b x=%b expected cyc=%0d code=%h p=%b x=%b",
                 i, obs_ev[i].cyc, obs_ev[i].code, obs_ev[i].pressed, obs_ev[i].extended,
                 exp_ev[i].cyc, exp_ev[i].code, exp_ev[i].pressed, exp_ev[i].extended);
      end
    end
  endtask

  task automatic test_errors;
    clear_q();
    send_frame(8'h1C, 1, 0, FILTER + 4, -1);
    send_frame(8'hF0, 0, 0, FILTER + 4, -1);
    send_frame(8'h33, 0, 1, FILTER + 4, -1);
    send_frame(8'h1C, 0, 0, FILTER + 4, -1);
    tests++;
    if (obs_err.size() != exp_err.size() || obs_err.size() != 2) begin
      fails++;
      $display("FAIL errors_err_count: got %0d expected 2", obs_err.size());
    end
    for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++) begin
      tests++;
      if (obs_err[i] !== exp_err[i]) begin
        fails++;
        $display("FAIL errors_err%0d_cycle: got %0d expected %0d", i, obs_err[i], exp_err[i]);
      end
    end
    tests++;
    if (obs_ev.size() != 1 || obs_ev[0] !== exp_ev[0] || obs_ev[0].pressed !== 1'b1) begin
      fails++;
      $display("FAIL errors_strobe: got n=%0d expected 1 event code=1c p=1", obs_ev.size());
    end
  endtask

  task automatic test_glitch;
    clear_q();
    send_frame(8'h29, 0, 0, FILTER + 6, 3);
    tests++;
    if (obs_ev.size() != 1 || obs_err.size() != 0) begin
      fails++;
      $display("FAIL glitch_count: got %0d/%0d expected 1/0", obs_ev.size(), obs_err.size());
    end else begin
      tests++;
      if (obs_ev[0] !== exp_ev[0] || obs_ev[0].code !== 8'h29) begin
        fails++;
        $display("FAIL glitch_ev: got cyc=%0d code=%h expected cyc=%0d code=29",
                 obs_ev[0].cyc, obs_ev[0].code, exp_ev[0].cyc);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    int         sel;
    clear_q();
    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(0, 9));
      b = (sel < 2) ? 8'hE0 : (sel < 4) ? 8'hF0 : 8'($urandom);
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 int'($urandom_range(FILTER + 4, FILTER + 20)), -1);
    end
    tests++;
    if (obs_ev.size() != exp_ev.size() || obs_err.size() != exp_err.size()) begin
      fails++;
      $display("FAIL random_count: got %0d ev %0d err expected %0d ev %0d err",
               obs_ev.size(), obs_err.size(), exp_ev.size(), exp_err.size());
    end
    for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
      tests++;
      if (obs_ev[i] !== exp_ev[i]) begin
        fails++;
        $display("FAIL random_ev%0d: got cyc=%0d code=%h p=%b x=%b expected cyc=%0d code=%h p=%b x=%b",
                 i, obs_ev[i].cyc, obs_ev[i].code, obs_ev[i].pressed, obs_ev[i].extended,
                 exp_ev[i].cyc, exp_ev[i].code, exp_ev[i].pressed, exp_ev[i].extended);
      end
    end
    for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++) begin
      tests++;
      if (obs_err[i] !== exp_err[i]) begin
        fails++;
        $display("FAIL random_err%0d: got cyc=%0d expected cyc=%0d", i, obs_err[i], exp_err[i]);
      end
    end
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout;
    clear_q();
    send_frame(8'hE0, 0, 0, FILTER + 4, -1);
    send_partial(8'h5A, 3, FILTER + 4);
    repeat (3 * TIMEOUT) @(negedge clock);
    tests++;
    if (obs_err.size() != 1 || obs_ev.size() != 0) begin
      fails++;
      $display("FAIL timeout_err: got %0d err %0d ev expected 1 err 0 ev", obs_err.size(),
               obs_ev.size());
    end
    send_frame(8'h5A, 0, 0, FILTER + 4, -1);
    tests++;
    if (obs_ev.size() != 1 || obs_ev[0] !== exp_ev[0] || obs_ev[0].code !== 8'h5A) begin
      fails++;
      $display("FAIL timeout_recover: got n=%0d expected one event code=5a x=%b", obs_ev.size(),
               exp_ev[0].extended);
    end
  endtask
`endif

  task automatic test_exclusive;
    tests++;
    if (both_cnt != 0) begin
      fails++;
      $display("FAIL strobe_err_overlap: got %0d cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_errors();
    test_glitch();
    test_random();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`endif
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- PS/2 device-to-host receiver. Samples raw PS/2 clock/data lines and deframes 11-bit frames.
- Collapses E0 (extended) and F0 (break) prefixes into a single event per key.
- Produces the code/strobe/pressed event interface consumed by the keyboard matrix block.
- Sits between the board PS/2 pins and the keyboard matrix; receive only, never drives the lines.

Parameters:
- FILTER, 8: consecutive identical synchronized samples required before the filtered ps2_clk changes state.
- TIMEOUT, 50000: clock cycles of ps2_clk inactivity mid-frame before the frame is aborted. Used only with PS2_TIMEOUT_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- code  out  8  scan code of the last completed key event, prefixes stripped.
- strobe  out  1  one-cycle pulse: code/pressed/extended are valid.
- pressed  out  1  1 = make, 0 = break (F0 seen).
- extended  out  1  1 = E0 prefix preceded this code.
- frame_err  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset (synchronous, active-high, takes priority over every other event): all outputs 0. FSM goes to IDLE. Shift register, bit counter, prefix flags and filter cleared. Filtered clock is set to 1. Reset asserted mid-frame discards the partial frame with no strobe and no frame_err.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - Filtered clock toggles only after FILTER consecutive equal samples that differ from its current value.
  - Falling edge = filtered clock goes 1->0. Data is sampled from synchronized ps2_data on that same cycle.
- FSM states, advancing only on falling edges:
  - IDLE: data 0 -> DATA, bit count 0. Data 1 (bad start bit) -> stay in IDLE, no error.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: evaluate the frame -> IDLE.
- Frame is valid only if the stop bit is 1 and the XOR of the 8 data bits plus the parity bit is 1 (odd parity).
- Invalid frame:
  - frame_err pulses for 1 cycle, on the cycle after the stop-bit edge.
  - Both prefix flags are cleared.
  - No strobe.
- Valid byte handling, in the cycle after the stop-bit edge:
  - E0: set the ext flag. No strobe.
  - F0: set the brk flag. No strobe.
  - Any other byte, including E1 and AA:
    - code <= byte, pressed <= ~brk, extended <= ext.
    - strobe = 1 for exactly one cycle.
    - ext and brk are cleared.
- Latency: strobe occurs exactly 1 clock after the cycle the filtered stop-bit falling edge is detected.
- code, pressed and extended hold their values until the next strobe.
- Repeated prefixes: F0 F0 and E0 E0 are idempotent. Prefix order is free: E0 F0 xx and F0 E0 xx both give extended=1, pressed=0.
- strobe and frame_err are never high in the same cycle.
- No output ever depends combinationally on the pins.

Optional Feature:
- Macro: PS2_TIMEOUT_EN.
- Defined: a counter resets on every falling edge and counts while the FSM is not IDLE. When it reaches TIMEOUT:
  - FSM -> IDLE, partial byte discarded.
  - frame_err pulses 1 cycle.
  - Prefix flags are kept.
  - This recovers bit-slip after hot-plug or a lost edge.
- Not defined: no counter logic. A partial frame waits indefinitely for further edges.

Test Plan:
- Reset: hold reset 3 cycles mid-frame -> all outputs 0, FSM IDLE. The next valid frame 1C gives strobe with code=1C, pressed=1, extended=0.
- Make/break: frames 1C, F0, 1C -> exactly two strobes: (code=1C, pressed=1, extended=0), then (code=1C, pressed=0, extended=0). No strobe for F0. Each strobe is exactly 1 cycle wide, 1 clock after the stop edge.
- Extended: frames E0 75, E0 F0 75 -> strobes (75, pressed=1, extended=1), then (75, pressed=0, extended=1). A following plain 75 gives extended=0.
- Errors:
  - Frame 1C with even parity -> frame_err 1 cycle, no strobe.
  - F0, then a frame with stop bit 0, then 1C -> frame_err on the bad frame, then strobe code=1C, pressed=1 (brk flag was cleared).
- Glitch filter: a ps2_clk low pulse of FILTER-1 cycles inside a bit period -> no bit consumed. Frame 29 still decodes to code=29.
- With PS2_TIMEOUT_EN, TIMEOUT=100: send start bit plus 3 data bits, idle 100 cycles -> frame_err pulse, FSM IDLE. The next full frame 5A gives strobe code=5A.
